// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: state encodings and
// handshake level names used by the EX stage.
package div_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'b00;
    localparam state_t S_DIVZERO = 2'b01;
    localparam state_t S_ON      = 2'b10;
    localparam state_t S_END     = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake bundle. EX drives the request side (master),
// the divider answers with result, ready and stall request (slave).
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic               signed_i;
    logic [WIDTH-1:0]   dividend_i;
    logic [WIDTH-1:0]   divisor_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stall_req_o;

    modport master (
        output start_i, annul_i, signed_i, dividend_i, divisor_i,
        input  result_o, ready_o, stall_req_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, dividend_i, divisor_i,
        output result_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU; one quotient bit per
// cycle, result held as {remainder, quotient} until EX drops start_i.
//
//   state   | meaning
//   IDLE    | waiting for start_i with no annul_i
//   DIVZERO | divisor was zero, fixed result is produced
//   ON      | shift-subtract iterations, then sign fix-up
//   END     | result_o valid, held until start_i drops
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               dvd_neg, dvs_neg;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign dvd_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
    assign dvs_neg = bus.signed_i & bus.divisor_i[WIDTH-1];

    // dvd_q shifts the dividend out at the top and collects quotient bits at the bottom
    assign partial = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = partial - {1'b0, dvs_q};
    assign fits    = partial >= {1'b0, dvs_q};

    assign quo_fix = quo_neg_q ? -dvd_q : dvd_q;
    assign rem_fix = rem_neg_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i == DIV_START && !bus.annul_i) begin
                    cnt_d = '0;
                    rem_d = '0;
                    if (bus.divisor_i == '0) begin
                        state_d = S_DIVZERO;
                        dvd_d   = bus.dividend_i;
                    end else begin
                        state_d   = S_ON;
                        dvd_d     = dvd_neg ? -bus.dividend_i : bus.dividend_i;
                        dvs_d     = dvs_neg ? -bus.divisor_i  : bus.divisor_i;
                        quo_neg_d = dvd_neg ^ dvs_neg;
                        rem_neg_d = dvd_neg;
                    end
                end
            end
            S_DIVZERO: begin
                if (bus.annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == '0) begin
                    // two-cycle zero-divisor path keeps the EX-side latency fixed
                    cnt_d = CW'(1);
                end else begin
                    state_d  = S_END;
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                    ready_d  = DIV_RESULT_READY;
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == CW'(WIDTH)) begin
                    state_d  = S_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    rem_d = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], fits};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_END: begin
                if (bus.annul_i || bus.start_i == DIV_STOP) begin
                    state_d  = S_IDLE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o    = result_q;
    assign bus.ready_o     = ready_q;
    assign bus.stall_req_o = !rst && (bus.start_i == DIV_START) && (state_q != S_END) && !bus.annul_i;

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and quotient/remainder width in bits.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start_i  in  1  divide request, held high by EX until result consumed.
REQ-005 annul_i  in  1  cancel in-flight divide (pipeline flush).
REQ-006 signed_i  in  1  1 = DIV/REM (signed), 0 = DIVU/REMU.
REQ-007 dividend_i  in  WIDTH  rs1 value, sampled only on accept.
REQ-008 divisor_i  in  WIDTH  rs2 value, sampled only on accept.
REQ-009 result_o  out  2*WIDTH  {remainder, quotient}, registered.
REQ-010 ready_o  out  1  result_o valid, registered.
REQ-011 stall_req_o  out  1  combinational stall request to pipeline control.

Function
REQ-012 FSM states IDLE, DIVZERO, ON, END; shall use an iteration counter 0..WIDTH.
REQ-013 Accept: IDLE and start_i=1 and annul_i=0; operands latched at that edge.
REQ-014 On accept with divisor 0: next state DIVZERO; otherwise ON with counter 0.
REQ-015 Signed mode: operands converted to magnitudes at accept; quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
REQ-016 ON: one restoring shift-subtract step per cycle on unsigned magnitudes, (WIDTH+1)-bit partial remainder compare; counter increments each cycle.
REQ-017 After WIDTH ON cycles: apply sign fix-up, load result_o, next state END.
REQ-018 Latency: ready_o high WIDTH+1 edges after the accepting edge (33 for WIDTH=32); divide-by-zero: 2 edges.
REQ-019 DIVZERO: quotient = all ones, remainder = dividend (signed and unsigned), next state END.
REQ-020 Overflow (signed, dividend = -2^(WIDTH-1), divisor = -1): quotient = -2^(WIDTH-1), remainder = 0, produced by normal iteration.
REQ-021 END: ready_o=1, result_o held stable while start_i=1; start_i=0 -> IDLE, ready_o=0 next edge.
REQ-022 start_i=1 in END is not a new request; a new divide requires start_i low for at least one cycle.
REQ-023 annul_i=1 in DIVZERO or ON -> IDLE next edge, ready_o=0, result_o=0; annul_i in END -> IDLE.
REQ-024 annul_i has priority over every transition; annul_i and start_i together in IDLE -> no accept.
REQ-025 Operand changes after accept shall not affect the result.
REQ-026 stall_req_o = start_i AND NOT (state==END) AND NOT annul_i.

Reset
REQ-027 rst=1 at an edge: state IDLE, counter 0, result_o 0, ready_o 0, regardless of state; rst overrides annul_i/start_i.
REQ-028 stall_req_o shall be 0 while rst=1.

Structure
REQ-029 State encodings, DivResultReady/NotReady, DivStart/Stop constants live in the shared defines file.
REQ-030 Single module; EX instantiates it and muxes result_o halves for DIV*/REM* aluops; no sub-module.

Verification
REQ-031 Unsigned 100/7 -> ready_o at edge 33, result_o {2, 14}; stall_req_o high cycles 0..32.
REQ-032 Signed -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1 (0xFFFFFFFF).
REQ-033 Divisor 0, dividend 0x1234 -> after 2 edges quotient 0xFFFFFFFF, remainder 0x1234.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-035 annul_i at ON cycle 10 -> IDLE next edge, ready_o 0; new start 5/5 then gives {0, 1}.
REQ-036 rst mid-ON (cycle 20) -> all outputs 0 next edge; start_i held through END keeps result stable, drop -> IDLE.
